// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between fetch and load/store.
// dmem has fixed priority; imem is forced through after STARVE_LIMIT losses.
module mem_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            imem_req_valid,
  output logic            imem_req_ready,
  input  logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_fcn,
  input  logic [2:0]      imem_req_typ,
  input  logic [XLEN-1:0] imem_req_data,
  output logic            imem_res_valid,
  output logic [XLEN-1:0] imem_res_data,
  input  logic            dmem_req_valid,
  output logic            dmem_req_ready,
  input  logic [XLEN-1:0] dmem_req_addr,
  input  logic            dmem_req_fcn,
  input  logic [2:0]      dmem_req_typ,
  input  logic [XLEN-1:0] dmem_req_data,
  output logic            dmem_res_valid,
  output logic [XLEN-1:0] dmem_res_data,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  output logic            mem_req_fcn,
  output logic [2:0]      mem_req_typ,
  output logic [XLEN-1:0] mem_req_data,
  input  logic            mem_res_valid,
  input  logic [XLEN-1:0] mem_res_data,
  output logic            busy,
  output logic            owner,
  output logic            protocol_err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          perr_q, perr_d;
  logic          lock_q, lock_d;
  logic          lock_own_q, lock_own_d;
  logic [SW-1:0] streak_q, streak_d;

  logic gnt;
  logic gnt_valid;
  logic idle;
  logic bsy;
  logic accept;

  // gnt: 1 selects dmem, 0 selects imem
  always_comb begin
    if (lock_q) begin
      gnt = lock_own_q;
    end else if (imem_req_valid && dmem_req_valid) begin
      gnt = (streak_q != LIM);
    end else begin
      gnt = dmem_req_valid;
    end
  end

  assign idle      = (state_q == IDLE) && !reset;
  assign bsy       = (state_q == BUSY) && !reset;
  assign gnt_valid = gnt ? dmem_req_valid : imem_req_valid;

  assign mem_req_valid = idle && gnt_valid;
  assign accept        = mem_req_valid && mem_req_ready;

  assign imem_req_ready = mem_req_valid && !gnt && mem_req_ready;
  assign dmem_req_ready = mem_req_valid && gnt && mem_req_ready;

  assign mem_req_addr = gnt ? dmem_req_addr : imem_req_addr;
  assign mem_req_fcn  = gnt ? dmem_req_fcn  : imem_req_fcn;
  assign mem_req_typ  = gnt ? dmem_req_typ  : imem_req_typ;
  assign mem_req_data = gnt ? dmem_req_data : imem_req_data;

  assign imem_res_valid = bsy && mem_res_valid && !owner_q;
  assign dmem_res_valid = bsy && mem_res_valid && owner_q;
  assign imem_res_data  = mem_res_data;
  assign dmem_res_data  = mem_res_data;

  assign busy         = (state_q == BUSY);
  assign owner        = owner_q;
  assign protocol_err = perr_q;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    perr_d     = perr_q;
    lock_d     = lock_q;
    lock_own_d = lock_own_q;
    streak_d   = streak_q;
    unique case (state_q)
      IDLE: begin
        if (mem_res_valid) begin
          perr_d = 1'b1;
        end
        if (accept) begin
          state_d = BUSY;
          owner_d = gnt;
          lock_d  = 1'b0;
          if (!gnt) begin
            streak_d = '0;
          end else if (imem_req_valid && streak_q != LIM) begin
            streak_d = streak_q + 1'b1;
          end
        end else if (mem_req_valid) begin
          lock_d     = 1'b1;
          lock_own_d = gnt;
        end
      end
      BUSY: begin
        if (mem_res_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      perr_q     <= 1'b0;
      lock_q     <= 1'b0;
      lock_own_q <= 1'b0;
      streak_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      perr_q     <= perr_d;
      lock_q     <= lock_d;
      lock_own_q <= lock_own_d;
      streak_q   <= streak_d;
    end
  end

endmodule
